// File: rtl/updi_txn_sequencer.sv
// Sequences one UPDI exchange: TX instruction bytes, optional ACK wait, optional RX read.
// Optional retry-on-timeout is enabled by defining UPDI_SEQ_RETRY_EN.
module updi_txn_sequencer #(
    parameter int BITS_N      = 6,
    parameter int MAX_RETRIES = 3,
    localparam int RW         = $clog2(MAX_RETRIES + 1)
) (
    input  logic              clk,
    input  logic              rst,
    // Requester: a request is accepted on the cycle req_valid and req_ready are both high.
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [BITS_N-1:0] req_tx_bytes,
    input  logic              req_ack,
    input  logic [BITS_N-1:0] req_rx_bytes,
    output logic              rsp_done,
    output logic [1:0]        rsp_status,
    output logic [RW-1:0]     rsp_retries,
    output logic              rsp_flush,
    // Transmit handler
    output logic              tx_start,
    output logic [BITS_N-1:0] tx_n_bytes,
    input  logic              tx_ready,
    input  logic              tx_done,
    // Input handler
    output logic              rx_start,
    output logic [BITS_N-1:0] rx_n_bytes,
    output logic              rx_wait_ack,
    input  logic              rx_ready,
    input  logic              rx_done,
    input  logic              rx_timeout,
    input  logic              rx_ack_received,
    input  logic              rx_ack_error,
    output logic [3:0]        dbg_state
);

    localparam logic [3:0] S_IDLE      = 4'd0;
    localparam logic [3:0] S_TX_START  = 4'd1;
    localparam logic [3:0] S_TX_WAIT   = 4'd2;
    localparam logic [3:0] S_ACK_START = 4'd3;
    localparam logic [3:0] S_ACK_WAIT  = 4'd4;
    localparam logic [3:0] S_RX_START  = 4'd5;
    localparam logic [3:0] S_RX_WAIT   = 4'd6;
    localparam logic [3:0] S_RETRY     = 4'd7;
    localparam logic [3:0] S_DONE      = 4'd8;

    localparam logic [1:0] ST_OK      = 2'd0;
    localparam logic [1:0] ST_TIMEOUT = 2'd1;
    localparam logic [1:0] ST_NACK    = 2'd2;

    logic [3:0]        state, state_nx;
    logic [BITS_N-1:0] tx_bytes_q, tx_bytes_nx;
    logic [BITS_N-1:0] rx_bytes_q, rx_bytes_nx;
    logic              ack_q, ack_nx;
    logic [1:0]        status_q, status_nx;
    logic [3:0]        timeout_state;
    logic [1:0]        timeout_status;

    function automatic logic [3:0] first_phase(input logic [BITS_N-1:0] tx,
                                               input logic              ack,
                                               input logic [BITS_N-1:0] rx);
        if (tx != '0)      return S_TX_START;
        else if (ack)      return S_ACK_START;
        else if (rx != '0) return S_RX_START;
        else               return S_DONE;
    endfunction

    function automatic logic [3:0] after_tx(input logic ack, input logic [BITS_N-1:0] rx);
        if (ack)           return S_ACK_START;
        else if (rx != '0) return S_RX_START;
        else               return S_DONE;
    endfunction

`ifdef UPDI_SEQ_RETRY_EN
    localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRIES);

    logic [RW-1:0] retry_q, retry_nx;
    logic          retry_left;

    assign retry_left     = (retry_q < RETRY_MAX);
    assign timeout_state  = S_RETRY;
    assign timeout_status = status_q;
`else
    assign timeout_state  = S_DONE;
    assign timeout_status = ST_TIMEOUT;
`endif

    always_comb begin
        state_nx    = state;
        tx_bytes_nx = tx_bytes_q;
        rx_bytes_nx = rx_bytes_q;
        ack_nx      = ack_q;
        status_nx   = status_q;
`ifdef UPDI_SEQ_RETRY_EN
        retry_nx    = retry_q;
`endif
        case (state)
            S_IDLE: begin
                if (req_valid) begin
                    tx_bytes_nx = req_tx_bytes;
                    rx_bytes_nx = req_rx_bytes;
                    ack_nx      = req_ack;
                    status_nx   = ST_OK;
`ifdef UPDI_SEQ_RETRY_EN
                    retry_nx    = '0;
`endif
                    state_nx    = first_phase(req_tx_bytes, req_ack, req_rx_bytes);
                end
            end
            S_TX_START: begin
                if (tx_ready) state_nx = S_TX_WAIT;
            end
            S_TX_WAIT: begin
                if (tx_done) state_nx = after_tx(ack_q, rx_bytes_q);
            end
            S_ACK_START: begin
                if (rx_ready) state_nx = S_ACK_WAIT;
            end
            S_ACK_WAIT: begin
                // Error beats a simultaneous ACK; a timeout loses to either.
                if (rx_ack_error) begin
                    state_nx  = S_DONE;
                    status_nx = ST_NACK;
                end else if (rx_ack_received) begin
                    state_nx  = (rx_bytes_q != '0) ? S_RX_START : S_DONE;
                end else if (rx_timeout) begin
                    state_nx  = timeout_state;
                    status_nx = timeout_status;
                end
            end
            S_RX_START: begin
                if (rx_ready) state_nx = S_RX_WAIT;
            end
            S_RX_WAIT: begin
                if (rx_done) begin
                    state_nx  = S_DONE;
                end else if (rx_timeout) begin
                    state_nx  = timeout_state;
                    status_nx = timeout_status;
                end
            end
            S_RETRY: begin
`ifdef UPDI_SEQ_RETRY_EN
                // Retries always restart from the first enabled phase, normally TX.
                if (retry_left) begin
                    retry_nx = retry_q + RW'(1);
                    state_nx = first_phase(tx_bytes_q, ack_q, rx_bytes_q);
                end else begin
                    state_nx  = S_DONE;
                    status_nx = ST_TIMEOUT;
                end
`else
                state_nx  = S_DONE;
                status_nx = ST_TIMEOUT;
`endif
            end
            S_DONE: begin
                state_nx = S_IDLE;
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            tx_bytes_q <= '0;
            rx_bytes_q <= '0;
            ack_q      <= 1'b0;
            status_q   <= ST_OK;
`ifdef UPDI_SEQ_RETRY_EN
            retry_q    <= '0;
`endif
        end else begin
            state      <= state_nx;
            tx_bytes_q <= tx_bytes_nx;
            rx_bytes_q <= rx_bytes_nx;
            ack_q      <= ack_nx;
            status_q   <= status_nx;
`ifdef UPDI_SEQ_RETRY_EN
            retry_q    <= retry_nx;
`endif
        end
    end

    // Everything is forced low while rst is high, even before the state register clears.
    assign req_ready   = ~rst & (state == S_IDLE);
    assign tx_start    = ~rst & (state == S_TX_START) & tx_ready;
    assign tx_n_bytes  = rst ? '0 : tx_bytes_q;
    assign rx_wait_ack = ~rst & (state == S_ACK_START) & rx_ready;
    assign rx_start    = ~rst & (state == S_RX_START) & rx_ready;
    assign rx_n_bytes  = rst ? '0 : rx_bytes_q;
    assign rsp_done    = ~rst & (state == S_DONE);
    assign rsp_status  = rst ? ST_OK : status_q;
    assign dbg_state   = rst ? S_IDLE : state;

`ifdef UPDI_SEQ_RETRY_EN
    assign rsp_flush   = ~rst & (state == S_RETRY) & retry_left;
    assign rsp_retries = rst ? '0 : retry_q;
`else
    assign rsp_flush   = 1'b0;
    assign rsp_retries = '0;
`endif

endmodule

// File: tb/tb_updi_txn_sequencer.sv
// Bench for updi_txn_sequencer: scenario tasks drive the handler side by hand, a monitor
// scores every rsp_done against the expected queue.
module tb_updi_txn_sequencer;

    localparam int BITS_N      = 6;
    localparam int MAX_RETRIES = 3;
    localparam int RW          = $clog2(MAX_RETRIES + 1);
    localparam int EW          = 2 + RW;
`ifdef UPDI_SEQ_RETRY_EN
    localparam bit RETRY_EN = 1'b1;
`else
    localparam bit RETRY_EN = 1'b0;
`endif

    logic              clk;
    logic              rst;
    logic              req_valid;
    logic              req_ready;
    logic [BITS_N-1:0] req_tx_bytes;
    logic              req_ack;
    logic [BITS_N-1:0] req_rx_bytes;
    logic              rsp_done;
    logic [1:0]        rsp_status;
    logic [RW-1:0]     rsp_retries;
    logic              rsp_flush;
    logic              tx_start;
    logic [BITS_N-1:0] tx_n_bytes;
    logic              tx_ready;
    logic              tx_done;
    logic              rx_start;
    logic [BITS_N-1:0] rx_n_bytes;
    logic              rx_wait_ack;
    logic              rx_ready;
    logic              rx_done;
    logic              rx_timeout;
    logic              rx_ack_received;
    logic              rx_ack_error;
    logic [3:0]        dbg_state;

    int total = 0;
    int bad   = 0;
    logic [EW-1:0] exp_q[$];
    logic [EW-1:0] mon_exp;
    int n_tx_start = 0;
    int n_wait_ack = 0;
    int n_rx_start = 0;
    int n_flush    = 0;

    updi_txn_sequencer #(.BITS_N(BITS_N), .MAX_RETRIES(MAX_RETRIES)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_tx_bytes(req_tx_bytes), .req_ack(req_ack), .req_rx_bytes(req_rx_bytes),
        .rsp_done(rsp_done), .rsp_status(rsp_status), .rsp_retries(rsp_retries),
        .rsp_flush(rsp_flush),
        .tx_start(tx_start), .tx_n_bytes(tx_n_bytes), .tx_ready(tx_ready), .tx_done(tx_done),
        .rx_start(rx_start), .rx_n_bytes(rx_n_bytes), .rx_wait_ack(rx_wait_ack),
        .rx_ready(rx_ready), .rx_done(rx_done), .rx_timeout(rx_timeout),
        .rx_ack_received(rx_ack_received), .rx_ack_error(rx_ack_error),
        .dbg_state(dbg_state)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog got=running want=finished");
        $fatal(1, "watchdog expired");
    end

    // Monitor and scoreboard: sampled on the falling edge
    always @(negedge clk) begin
        if (!rst) begin
            if (tx_start)    n_tx_start++;
            if (rx_wait_ack) n_wait_ack++;
            if (rx_start)    n_rx_start++;
            if (rsp_flush)   n_flush++;
            total++;
            if ((rx_start && rx_wait_ack) || (tx_start && (rx_start || rx_wait_ack))) begin
                bad++;
                $display("FAIL cmd_exclusive got=tx%0b/rx%0b/ack%0b want=at_most_one",
                         tx_start, rx_start, rx_wait_ack);
            end
            if (rsp_done) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL rsp_unexpected got=status%0d want=no_rsp_done", rsp_status);
                end else begin
                    mon_exp = exp_q.pop_front();
                    if ({rsp_status, rsp_retries} !== mon_exp) begin
                        bad++;
                        $display("FAIL rsp_status_retries got=%0d/%0d want=%0d/%0d",
                                 rsp_status, rsp_retries, mon_exp[EW-1 -: 2], mon_exp[RW-1:0]);
                    end
                end
            end
        end
    end

    // Driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_req(input int tx, input bit ack, input int rx);
        bit got;
        got          = 1'b0;
        req_tx_bytes = BITS_N'(tx);
        req_ack      = ack;
        req_rx_bytes = BITS_N'(rx);
        req_valid    = 1'b1;
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge clk);
            got = req_ready;
        end
        if (!got) begin
            total++;
            bad++;
            $display("FAIL wait_req_ready got=timeout want=ready");
        end
        tick();
        req_valid = 1'b0;
    endtask

    task automatic wait_sig(input int sel, input string name);
        bit got;
        got = 1'b0;
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge clk);
            case (sel)
                0:       got = tx_start;
                1:       got = rx_wait_ack;
                2:       got = rx_start;
                3:       got = rsp_done;
                default: got = req_ready;
            endcase
        end
        if (!got) begin
            total++;
            bad++;
            $display("FAIL wait_%s got=timeout want=seen", name);
        end
    endtask

    task automatic pulse_in(input int sel);
        case (sel)
            0:       tx_done         = 1'b1;
            1:       rx_ack_received = 1'b1;
            2:       rx_ack_error    = 1'b1;
            3:       rx_timeout      = 1'b1;
            default: rx_done         = 1'b1;
        endcase
        tick();
        tx_done = 1'b0; rx_ack_received = 1'b0; rx_ack_error = 1'b0;
        rx_timeout = 1'b0; rx_done = 1'b0;
    endtask

    task automatic run_ok_txn(input int tx, input bit ack, input int rx);
        exp_q.push_back({2'd0, {RW{1'b0}}});
        send_req(tx, ack, rx);
        if (tx != 0) begin
            wait_sig(0, "tx_start"); tick(); pulse_in(0);
        end
        if (ack) begin
            wait_sig(1, "rx_wait_ack"); tick(); pulse_in(1);
        end
        if (rx != 0) begin
            wait_sig(2, "rx_start");
            total++;
            if (rx_n_bytes !== BITS_N'(rx)) begin
                bad++;
                $display("FAIL b2b_rx_n_bytes got=%0d want=%0d", rx_n_bytes, rx);
            end
            tick(); pulse_in(4);
        end
        wait_sig(3, "rsp_done");
        tick();
    endtask

    // Scenarios
    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        @(negedge clk);
        total++;
        if ({req_ready, rsp_done, rsp_flush, tx_start, rx_start, rx_wait_ack} !== 6'd0) begin
            bad++;
            $display("FAIL reset_ctrl got=%b want=000000",
                     {req_ready, rsp_done, rsp_flush, tx_start, rx_start, rx_wait_ack});
        end
        total++;
        if ({tx_n_bytes, rx_n_bytes, rsp_status, rsp_retries} !== '0) begin
            bad++;
            $display("FAIL reset_data got=%0d/%0d/%0d/%0d want=0/0/0/0",
                     tx_n_bytes, rx_n_bytes, rsp_status, rsp_retries);
        end
        tick();
        rst = 1'b0;
        @(negedge clk);
        total++;
        if (req_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_release_ready got=%b want=1", req_ready);
        end
        tick();
    endtask

    task automatic test_tx_ack();
        int c0, w0;
        c0 = n_tx_start; w0 = n_wait_ack;
        exp_q.push_back({2'd0, {RW{1'b0}}});
        send_req(2, 1'b1, 0);
        @(negedge clk);
        total++;
        if (tx_start !== 1'b1 || tx_n_bytes !== 6'd2) begin
            bad++;
            $display("FAIL txack_tx_start got=%b/%0d want=1/2", tx_start, tx_n_bytes);
        end
        tick(); pulse_in(0);
        @(negedge clk);
        total++;
        if (rx_wait_ack !== 1'b1 || rx_start !== 1'b0) begin
            bad++;
            $display("FAIL txack_wait_ack got=%b/%b want=1/0", rx_wait_ack, rx_start);
        end
        tick();
        repeat (4) tick();
        pulse_in(1);
        @(negedge clk);
        total++;
        if (rsp_done !== 1'b1) begin
            bad++;
            $display("FAIL txack_done_latency got=%b want=1", rsp_done);
        end
        tick();
        @(negedge clk);
        total++;
        if (req_ready !== 1'b1) begin
            bad++;
            $display("FAIL txack_ready_return got=%b want=1", req_ready);
        end
        tick();
        total++;
        if (n_tx_start - c0 != 1 || n_wait_ack - w0 != 1) begin
            bad++;
            $display("FAIL txack_cmd_count got=%0d/%0d want=1/1", n_tx_start - c0, n_wait_ack - w0);
        end
    endtask

    task automatic test_tx_rx();
        exp_q.push_back({2'd0, {RW{1'b0}}});
        send_req(3, 1'b0, 4);
        wait_sig(0, "tx_start");
        tick(); pulse_in(0);
        @(negedge clk);
        total++;
        if (rx_start !== 1'b1 || rx_n_bytes !== 6'd4 || rx_wait_ack !== 1'b0) begin
            bad++;
            $display("FAIL txrx_rx_start got=%b/%0d/%b want=1/4/0", rx_start, rx_n_bytes, rx_wait_ack);
        end
        tick();
        repeat (4) tick();
        pulse_in(4);
        @(negedge clk);
        total++;
        if (rsp_done !== 1'b1) begin
            bad++;
            $display("FAIL txrx_done_latency got=%b want=1", rsp_done);
        end
        tick();
    endtask

    task automatic test_retry();
        int c0, f0, attempts;
        c0 = n_tx_start; f0 = n_flush;
        attempts = RETRY_EN ? MAX_RETRIES + 1 : 1;
        exp_q.push_back({2'd1, RW'(RETRY_EN ? MAX_RETRIES : 0)});
        send_req(2, 1'b1, 0);
        for (int a = 0; a < attempts; a++) begin
            wait_sig(0, "retry_tx_start"); tick(); pulse_in(0);
            wait_sig(1, "retry_wait_ack"); tick();
            repeat (2) tick();
            pulse_in(3);
        end
        wait_sig(3, "retry_rsp_done");
        tick();
        total++;
        if (n_tx_start - c0 != attempts) begin
            bad++;
            $display("FAIL retry_tx_count got=%0d want=%0d", n_tx_start - c0, attempts);
        end
        total++;
        if (n_flush - f0 != (RETRY_EN ? MAX_RETRIES : 0)) begin
            bad++;
            $display("FAIL retry_flush_count got=%0d want=%0d", n_flush - f0,
                     RETRY_EN ? MAX_RETRIES : 0);
        end
    endtask

    task automatic test_nack();
        int c0, r0, f0;
        c0 = n_tx_start; r0 = n_rx_start; f0 = n_flush;
        exp_q.push_back({2'd2, {RW{1'b0}}});
        send_req(1, 1'b1, 0);
        wait_sig(0, "nack_tx_start"); tick(); pulse_in(0);
        wait_sig(1, "nack_wait_ack"); tick();
        pulse_in(2);
        @(negedge clk);
        total++;
        if (rsp_done !== 1'b1) begin
            bad++;
            $display("FAIL nack_done got=%b want=1", rsp_done);
        end
        tick();
        // Error and ACK together: error must win, so no RX phase follows.
        exp_q.push_back({2'd2, {RW{1'b0}}});
        send_req(1, 1'b1, 3);
        wait_sig(0, "nack2_tx_start"); tick(); pulse_in(0);
        wait_sig(1, "nack2_wait_ack"); tick();
        rx_ack_error = 1'b1; rx_ack_received = 1'b1;
        tick();
        rx_ack_error = 1'b0; rx_ack_received = 1'b0;
        @(negedge clk);
        total++;
        if (rsp_done !== 1'b1 || rx_start !== 1'b0) begin
            bad++;
            $display("FAIL nack_priority got=%b/%b want=1/0", rsp_done, rx_start);
        end
        tick();
        // ACK together with timeout: ACK wins, TX phase skipped.
        exp_q.push_back({2'd0, {RW{1'b0}}});
        send_req(0, 1'b1, 0);
        @(negedge clk);
        total++;
        if (rx_wait_ack !== 1'b1 || tx_start !== 1'b0) begin
            bad++;
            $display("FAIL ack_only_start got=%b/%b want=1/0", rx_wait_ack, tx_start);
        end
        tick();
        rx_ack_received = 1'b1; rx_timeout = 1'b1;
        tick();
        rx_ack_received = 1'b0; rx_timeout = 1'b0;
        @(negedge clk);
        total++;
        if (rsp_done !== 1'b1) begin
            bad++;
            $display("FAIL ack_beats_timeout got=%b want=1", rsp_done);
        end
        tick();
        total++;
        if (n_tx_start - c0 != 2 || n_rx_start - r0 != 0 || n_flush - f0 != 0) begin
            bad++;
            $display("FAIL nack_counts got=%0d/%0d/%0d want=2/0/0",
                     n_tx_start - c0, n_rx_start - r0, n_flush - f0);
        end
    endtask

    task automatic test_empty();
        int s0;
        s0 = n_tx_start + n_wait_ack + n_rx_start;
        exp_q.push_back({2'd0, {RW{1'b0}}});
        send_req(0, 1'b0, 0);
        @(negedge clk);
        total++;
        if (rsp_done !== 1'b1) begin
            bad++;
            $display("FAIL empty_done_latency got=%b want=1", rsp_done);
        end
        tick();
        @(negedge clk);
        total++;
        if (req_ready !== 1'b1) begin
            bad++;
            $display("FAIL empty_ready_return got=%b want=1", req_ready);
        end
        tick();
        total++;
        if (n_tx_start + n_wait_ack + n_rx_start != s0) begin
            bad++;
            $display("FAIL empty_no_cmds got=%0d want=%0d", n_tx_start + n_wait_ack + n_rx_start, s0);
        end
    endtask

    task automatic test_tx_stall();
        tx_ready = 1'b0;
        exp_q.push_back({2'd0, {RW{1'b0}}});
        send_req(1, 1'b0, 0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            total++;
            if (tx_start !== 1'b0) begin
                bad++;
                $display("FAIL stall_tx_start cycle=%0d got=%b want=0", i, tx_start);
            end
            tick();
        end
        tx_ready = 1'b1;
        @(negedge clk);
        total++;
        if (tx_start !== 1'b1) begin
            bad++;
            $display("FAIL stall_release got=%b want=1", tx_start);
        end
        tick(); pulse_in(0);
        @(negedge clk);
        total++;
        if (rsp_done !== 1'b1) begin
            bad++;
            $display("FAIL stall_done got=%b want=1", rsp_done);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        send_req(0, 1'b0, 2);
        wait_sig(2, "rst_rx_start");
        tick();
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            total++;
            if (req_ready !== 1'b0 || rsp_done !== 1'b0) begin
                bad++;
                $display("FAIL midrst_outputs cycle=%0d got=%b/%b want=0/0", i, req_ready, rsp_done);
            end
            tick();
        end
        rst = 1'b0;
        @(negedge clk);
        total++;
        if (req_ready !== 1'b1 || rsp_done !== 1'b0) begin
            bad++;
            $display("FAIL midrst_release got=%b/%b want=1/0", req_ready, rsp_done);
        end
        tick();
        repeat (3) tick();
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 8; i++) begin
            run_ok_txn($urandom_range(0, 3), 1'($urandom_range(0, 1)), $urandom_range(0, 3));
        end
    endtask

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_tx_bytes = '0; req_ack = 1'b0; req_rx_bytes = '0;
        tx_ready = 1'b1; tx_done = 1'b0; rx_ready = 1'b1; rx_done = 1'b0;
        rx_timeout = 1'b0; rx_ack_received = 1'b0; rx_ack_error = 1'b0;
        test_reset();
        test_tx_ack();
        test_tx_rx();
        test_retry();
        test_nack();
        test_empty();
        test_tx_stall();
        test_reset_mid();
        test_back_to_back();
        repeat (3) tick();
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL leftover_expected got=%0d want=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
